// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter/sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int CMD_W = 16;

  // Width of a counter that must be able to hold the value tmo_cyc.
  function automatic int tmo_w(input int tmo_cyc);
    return $clog2(tmo_cyc + 1);
  endfunction

endpackage

// File: rtl/spi_arb_sched_rr_pick.sv
// Round-robin selector: first set request after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is pending.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int pos;

  // Scan ptr+1, ptr+2, ... ptr+NUM_REQ; the last candidate is ptr itself,
  // so the previous owner only wins when nobody else is asking.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        idx = IDX_W'(pos);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arb_sched.sv
// Shares one SPI master between NUM_REQ requesters: round-robin pick, one-cycle wrt, response or timeout.
// Latency: req seen in IDLE -> gnt/spi_cmd/spi_wrt next cycle; done -> rsp_vld next cycle; done -> next wrt GAP_CYC+2 cycles.
// Backpressure: requesters hold req until rsp_vld/rsp_err; new requests wait while a transaction or the idle gap is in progress.
module spi_arb_sched
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYC = 8,
  parameter int TMO_CYC = 2047
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CMD_W*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rsp_vld,
  output logic [NUM_REQ-1:0]       rsp_err,
  output logic [CMD_W-1:0]         rsp_data,
  output logic                     spi_wrt,
  output logic [CMD_W-1:0]         spi_cmd,
  input  logic                     spi_done,
  input  logic [CMD_W-1:0]         spi_rd_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = tmo_w(TMO_CYC);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cur_idx;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [TW-1:0]   tmo_cnt;
  logic [TW-1:0]   tmo_nxt;
  logic [7:0]      gap_cnt;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Value the timeout counter takes at the end of the current BUSY cycle;
  // the abort fires in the BUSY cycle where it reaches TMO_CYC, so BUSY
  // lasts exactly TMO_CYC cycles when no done arrives.
  assign tmo_nxt = tmo_cnt + TW'(1);

  // Sequencer FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IW'(NUM_REQ - 1);
      cur_idx  <= '0;
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
      gnt      <= '0;
      rsp_vld  <= '0;
      rsp_err  <= '0;
      rsp_data <= '0;
      spi_wrt  <= 1'b0;
      spi_cmd  <= '0;
    end else begin
      spi_wrt <= 1'b0;
      rsp_vld <= '0;
      rsp_err <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            cur_idx <= pick_idx;
            spi_cmd <= req_cmd[pick_idx*CMD_W +: CMD_W];
            gnt     <= ONE << pick_idx;
            spi_wrt <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          tmo_cnt <= tmo_nxt;
          if (spi_done) begin
            rsp_data <= spi_rd_data;
            rsp_vld  <= ONE << cur_idx;
            gnt      <= '0;
            ptr      <= cur_idx;
            gap_cnt  <= '0;
            state    <= GAP;
          end else if (tmo_nxt == TW'(TMO_CYC)) begin
            rsp_err  <= ONE << cur_idx;
            gnt      <= '0;
            ptr      <= cur_idx;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYC - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb_sched.sv
// Directed bench for spi_arb_sched: single request, rotation, pointer, timeout, done/timeout race, reset in BUSY.
module tb_spi_arb_sched;
  import spi_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int GAP_CYC = 8;
  localparam int TMO_CYC = 2047;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_cmd;
  logic [3:0]  gnt, rsp_vld, rsp_err;
  logic [15:0] rsp_data, spi_cmd, spi_rd_data;
  logic        spi_wrt, spi_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = -1;
  logic [15:0] last_rd = 16'h0000;

  spi_arb_sched #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd),
    .gnt(gnt), .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_done = -1;
  endtask

  task automatic wait_wrt(input string tag);
    int n;
    n = 0;
    while (spi_wrt !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_wrt_seen"}, 32'(spi_wrt), 32'd1);
  endtask

  // Wait for the launch, check owner/command, answer dly cycles after wrt.
  task automatic run_txn(input string tag, input logic [3:0] exp_gnt, input logic [15:0] exp_cmd,
                         input int dly, input logic [15:0] rd);
    wait_wrt(tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, "_cmd"}, 32'(spi_cmd), 32'(exp_cmd));
    if (last_done >= 0)
      chk({tag, "_gap"}, 32'((cyc - last_done) >= GAP_CYC + 2), 32'd1);
    step();
    chk({tag, "_wrt_pulse"}, 32'(spi_wrt), 32'd0);
    repeat (dly - 1) step();
    spi_done    = 1'b1;
    spi_rd_data = rd;
    last_done   = cyc;
    step();
    spi_done    = 1'b0;
    spi_rd_data = 16'hDEAD;
    chk({tag, "_vld"}, 32'(rsp_vld), 32'(exp_gnt));
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_data"}, 32'(rsp_data), 32'(rd));
    chk({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
    last_rd = rd;
  endtask

  initial begin
    rst         = 1'b1;
    req         = 4'b0000;
    req_cmd     = {16'hD003, 16'hC0DE, 16'hB001, 16'hA000};
    spi_done    = 1'b0;
    spi_rd_data = 16'h0000;
    step();
    step();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_vld", 32'(rsp_vld), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_wrt", 32'(spi_wrt), 32'd0);
    chk("rst_cmd", 32'(spi_cmd), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));

    // Stray done while idle is ignored.
    spi_done = 1'b1;
    spi_rd_data = 16'hBEEF;
    step();
    spi_done = 1'b0;
    step();
    chk("stray_done_vld", 32'(rsp_vld), 32'd0);
    chk("stray_done_data", 32'(rsp_data), 32'd0);

    // Single request from requester 2.
    req = 4'b0100;
    run_txn("single", 4'b0100, 16'hC0DE, 1100, 16'h1234);
    req = 4'b0000;
    step();
    chk("single_vld_pulse", 32'(rsp_vld), 32'd0);

    // Round robin with everyone requesting.
    do_reset();
    req = 4'b1111;
    run_txn("rr0", 4'b0001, 16'hA000, 40, 16'h5000);
    run_txn("rr1", 4'b0010, 16'hB001, 40, 16'h5001);
    run_txn("rr2", 4'b0100, 16'hC0DE, 40, 16'h5002);
    run_txn("rr3", 4'b1000, 16'hD003, 40, 16'h5003);
    run_txn("rr4", 4'b0001, 16'hA000, 40, 16'h5004);
    req = 4'b0000;

    // Pointer: requester 1 completes, then 0 and 1 ask; search starts at 2 and wraps to 0.
    do_reset();
    req = 4'b0010;
    run_txn("ptr_a", 4'b0010, 16'hB001, 30, 16'h6001);
    req = 4'b0011;
    run_txn("ptr_b", 4'b0001, 16'hA000, 30, 16'h6002);
    req = 4'b0000;

    // Timeout: pointer is 0, so requester 1 wins; no done is ever returned.
    req = 4'b0110;
    wait_wrt("tmo");
    chk("tmo_gnt", 32'(gnt), 32'b0010);
    repeat (TMO_CYC) step();
    chk("tmo_early_err", 32'(rsp_err), 32'd0);
    chk("tmo_still_gnt", 32'(gnt), 32'b0010);
    step();
    chk("tmo_err", 32'(rsp_err), 32'b0010);
    chk("tmo_vld", 32'(rsp_vld), 32'd0);
    chk("tmo_data_kept", 32'(rsp_data), 32'(last_rd));
    chk("tmo_gnt_drop", 32'(gnt), 32'd0);
    req = 4'b0100;
    step();
    chk("tmo_err_pulse", 32'(rsp_err), 32'd0);
    run_txn("tmo_next", 4'b0100, 16'hC0DE, 25, 16'h7002);
    req = 4'b0000;

    // Done lands in the very cycle the timeout would fire: done wins.
    req = 4'b0001;
    run_txn("race", 4'b0001, 16'hA000, TMO_CYC, 16'h8000);
    req = 4'b0000;
    step();
    chk("race_err_after", 32'(rsp_err), 32'd0);

    // Reset while BUSY: silent abort, requester 0 then wins.
    do_reset();
    req = 4'b0010;
    wait_wrt("rbusy");
    repeat (20) step();
    chk("rbusy_in_busy", 32'(dut.state), 32'(BUSY));
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1001;
    chk("rbusy_gnt", 32'(gnt), 32'd0);
    chk("rbusy_vld", 32'(rsp_vld), 32'd0);
    chk("rbusy_err", 32'(rsp_err), 32'd0);
    chk("rbusy_data", 32'(rsp_data), 32'd0);
    chk("rbusy_wrt", 32'(spi_wrt), 32'd0);
    chk("rbusy_cmd", 32'(spi_cmd), 32'd0);
    chk("rbusy_state", 32'(dut.state), 32'(IDLE));
    last_done = -1;
    step();
    chk("rbusy_next_gnt", 32'(gnt), 32'b0001);
    chk("rbusy_next_wrt", 32'(spi_wrt), 32'd1);
    chk("rbusy_next_cmd", 32'(spi_cmd), 32'hA000);
    run_txn("rbusy_txn", 4'b0001, 16'hA000, 20, 16'h9000);
    req = 4'b0000;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
